// File: rtl/stage_sequencer_if.sv
// rtl/stage_sequencer_if.sv - control/status bundle between the CPU core and its stage sequencer
interface stage_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int LAT_W = 4
);
  logic               rx_valid;
  logic [7:0]         rx_data;
  logic               load_done;
  logic [5*LAT_W-1:0] lat_cfg;
  logic               mem_ready;
  logic [PC_W-1:0]    npc;
  logic               stop_req;
  logic               step_en;
  logic               step_go;
  logic [1:0]         mode;
  logic [2:0]         stage;
  logic               fd_en;
  logic               de_en;
  logic               em_en;
  logic               mw_en;
  logic               wb_en;
  logic               wb_clr;
  logic [PC_W-1:0]    pc;
  logic [31:0]        retired;
  logic [7:0]         led;

  modport master (
    output rx_valid, rx_data, load_done, lat_cfg, mem_ready, npc, stop_req, step_en, step_go,
    input  mode, stage, fd_en, de_en, em_en, mw_en, wb_en, wb_clr, pc, retired, led
  );

  modport slave (
    input  rx_valid, rx_data, load_done, lat_cfg, mem_ready, npc, stop_req, step_en, step_go,
    output mode, stage, fd_en, de_en, em_en, mw_en, wb_en, wb_clr, pc, retired, led
  );
endinterface

// File: rtl/stage_sequencer.sv
// rtl/stage_sequencer.sv - boot/load/exec mode FSM with per-stage dwell timing for the multicycle core
module stage_sequencer #(
  parameter int         PC_W      = 10,
  parameter int         LAT_W     = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hAA
) (
  input logic              clk,
  input logic              rstn,
  stage_sequencer_if.slave bus
);
  typedef enum logic [1:0] {M_IDLE, M_LOAD, M_EXEC, M_HALT} mode_t;
  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WB, S_WB_CLEAR, S_PAUSE
  } stage_t;

  mode_t              mode_q, mode_d;
  stage_t             stage_q, stage_d;
  logic [LAT_W-1:0]   cnt_q, cnt_d;
  logic [5*LAT_W-1:0] lat_q, lat_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [31:0]        retired_q, retired_d;
  logic [4:0]         pulse_q, pulse_d;
  logic               clr_q, clr_d;
  logic [7:0]         led_q, led_d;
  logic [LAT_W-1:0]   cur_lat;

  always_comb begin
    cur_lat = '0;
    case (stage_q)
      S_FETCH:   cur_lat = lat_q[0*LAT_W +: LAT_W];
      S_DECODE:  cur_lat = lat_q[1*LAT_W +: LAT_W];
      S_EXECUTE: cur_lat = lat_q[2*LAT_W +: LAT_W];
      S_MEMORY:  cur_lat = lat_q[3*LAT_W +: LAT_W];
      S_WB:      cur_lat = lat_q[4*LAT_W +: LAT_W];
      default:   cur_lat = '0;
    endcase
  end

  always_comb begin
    mode_d    = mode_q;
    stage_d   = stage_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    retired_d = retired_q;
    pulse_d   = '0;
    clr_d     = 1'b0;
    // npc is taken in the cycle the registered mw_en is visible
    pc_d      = pulse_q[3] ? bus.npc : pc_q;
    case (mode_q)
      M_IDLE: begin
        if (bus.rx_valid && bus.rx_data == SYNC_BYTE) mode_d = M_LOAD;
      end
      M_LOAD: begin
        if (bus.load_done) begin
          mode_d  = M_EXEC;
          stage_d = S_FETCH;
          cnt_d   = '0;
          lat_d   = bus.lat_cfg;
        end
      end
      M_EXEC: begin
        case (stage_q)
          S_WB_CLEAR: begin
            clr_d     = 1'b1;
            retired_d = retired_q + 32'd1;
            if (bus.stop_req)     mode_d  = M_HALT;
            else if (bus.step_en) stage_d = S_PAUSE;
            else                  stage_d = S_FETCH;
          end
          S_PAUSE: begin
            if (bus.step_go || !bus.step_en) stage_d = S_FETCH;
          end
          default: begin
            if (cnt_q != cur_lat) begin
              cnt_d = cnt_q + 1'b1;
            end else if (stage_q != S_MEMORY || bus.mem_ready) begin
              pulse_d = 5'b00001 << stage_q;
              cnt_d   = '0;
              stage_d = stage_t'(stage_q + 3'd1);
            end
          end
        endcase
      end
      default: ;
    endcase
    led_d = 8'(pc_d) | {2'b00, mode_d, 4'b0000};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mode_q    <= M_IDLE;
      stage_q   <= S_FETCH;
      cnt_q     <= '0;
      lat_q     <= '0;
      pc_q      <= '0;
      retired_q <= '0;
      pulse_q   <= '0;
      clr_q     <= 1'b0;
      led_q     <= '0;
    end else begin
      mode_q    <= mode_d;
      stage_q   <= stage_d;
      cnt_q     <= cnt_d;
      lat_q     <= lat_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      pulse_q   <= pulse_d;
      clr_q     <= clr_d;
      led_q     <= led_d;
    end
  end

  assign bus.mode    = mode_q;
  assign bus.stage   = stage_q;
  assign bus.fd_en   = pulse_q[0];
  assign bus.de_en   = pulse_q[1];
  assign bus.em_en   = pulse_q[2];
  assign bus.mw_en   = pulse_q[3];
  assign bus.wb_en   = pulse_q[4];
  assign bus.wb_clr  = clr_q;
  assign bus.pc      = pc_q;
  assign bus.retired = retired_q;
  assign bus.led     = led_q;
endmodule

// File: tb/tb_stage_sequencer.sv
// tb/tb_stage_sequencer.sv - scoreboard bench: expected pulse events queued by stimulus, checked by a monitor
module tb_stage_sequencer;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;
  ev_t exp_q[$];

  stage_sequencer_if #(.PC_W(10), .LAT_W(4)) bus ();

  stage_sequencer #(.PC_W(10), .LAT_W(4), .SYNC_BYTE(8'hAA)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // pulse kinds: 0 fd, 1 de, 2 em, 3 mw, 4 wb, 5 wb_clr
  always @(negedge clk) begin
    logic [5:0] pv;
    int k;
    ev_t e;
    pv = {bus.wb_clr, bus.wb_en, bus.mw_en, bus.em_en, bus.de_en, bus.fd_en};
    if (pv != 6'd0) begin
      k = 0;
      for (int i = 0; i < 6; i++) if (pv[i]) k = i;
      total++;
      if ($countones(pv) != 1) begin
        bad++;
        $display("FAIL pulse_exclusive: got %b expected one-hot (cycle %0d)", pv, cyc);
      end else if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: got kind %0d at cycle %0d expected none", k, cyc);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != k || e.cyc != cyc) begin
          bad++;
          $display("FAIL pulse_event: got kind %0d at cycle %0d expected kind %0d at cycle %0d",
                   k, cyc, e.kind, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic push_ev(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // instruction entering FETCH at cycle st; returns the cycle the following stage is entered
  task automatic push_instr(input int st, input int lf, input int ld, input int le,
                            input int lm, input int mwait, input int lw, output int nxt);
    int fd, de, em, mw, wb;
    fd = st + lf + 1;
    de = fd + ld + 1;
    em = de + le + 1;
    mw = em + lm + 1 + mwait;
    wb = mw + lw + 1;
    push_ev(0, fd); push_ev(1, de); push_ev(2, em);
    push_ev(3, mw); push_ev(4, wb); push_ev(5, wb + 1);
    nxt = wb + 1;
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.load_done = 1'b0;
    bus.mem_ready = 1'b1; bus.npc = 10'd5; bus.stop_req = 1'b0;
    bus.step_en = 1'b0; bus.step_go = 1'b0;
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
  endtask

  task automatic boot(output int s);
    bus.rx_valid = 1'b1; bus.rx_data = 8'hAA;
    tick();
    bus.rx_valid = 1'b0;
    chk("mode_after_sync", 32'(bus.mode), 32'd1);
    bus.load_done = 1'b1;
    tick();
    bus.load_done = 1'b0;
    chk("mode_after_load", 32'(bus.mode), 32'd2);
    chk("stage_after_load", 32'(bus.stage), 32'd0);
    s = cyc;
  endtask

  task automatic drain(input string nm);
    repeat (4) tick();
    chk(nm, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int s, n;
    bus.lat_cfg = 20'h00000;
    do_reset();
    chk("rst_mode", 32'(bus.mode), 32'd0);
    chk("rst_stage", 32'(bus.stage), 32'd0);
    chk("rst_pc", 32'(bus.pc), 32'd0);
    chk("rst_retired", bus.retired, 32'd0);
    chk("rst_led", 32'(bus.led), 32'd0);

    // non-sync byte ignored, then three plain instructions with a stop on the third
    bus.rx_valid = 1'b1; bus.rx_data = 8'h55;
    tick();
    bus.rx_valid = 1'b0;
    chk("mode_after_55", 32'(bus.mode), 32'd0);
    boot(s);
    push_instr(s, 0, 0, 0, 0, 0, 0, n);
    push_instr(n, 0, 0, 0, 0, 0, 0, n);
    push_instr(n, 0, 0, 0, 0, 0, 0, n);
    wait_cyc(s + 13);
    bus.stop_req = 1'b1;
    wait_cyc(s + 18);
    chk("halt_mode", 32'(bus.mode), 32'd3);
    chk("halt_retired", bus.retired, 32'd3);
    chk("halt_led54", 32'(bus.led[5:4]), 32'd3);
    chk("halt_led", 32'(bus.led), 32'h35);
    repeat (50) tick();
    chk("halt_still", 32'(bus.mode), 32'd3);
    bus.stop_req = 1'b0;
    drain("queue_t1");

    // execute dwell of 3; lat_cfg change mid-run must not matter
    bus.lat_cfg = 20'h00300;
    do_reset();
    boot(s);
    push_instr(s, 0, 0, 3, 0, 0, 0, n);
    wait_cyc(s + 7);
    chk("pc_on_mw", 32'(bus.pc), 32'd0);
    wait_cyc(s + 8);
    chk("pc_after_mw", 32'(bus.pc), 32'd5);
    chk("retired_before_clr", bus.retired, 32'd0);
    bus.lat_cfg = 20'hFFFFF;
    wait_cyc(s + 9);
    chk("retired_after_clr", bus.retired, 32'd1);
    push_instr(n, 0, 0, 3, 0, 0, 0, n);
    wait_cyc(s + 10);
    bus.stop_req = 1'b1;
    wait_cyc(s + 18);
    chk("t2_halt", 32'(bus.mode), 32'd3);
    chk("t2_retired", bus.retired, 32'd2);
    bus.stop_req = 1'b0;
    bus.lat_cfg = 20'h00000;
    drain("queue_t2");

    // mem_ready low for 7 cycles of MEMORY
    do_reset();
    bus.mem_ready = 1'b0;
    bus.stop_req = 1'b1;
    boot(s);
    push_instr(s, 0, 0, 0, 0, 7, 0, n);
    wait_cyc(s + 7);
    chk("mem_wait_stage", 32'(bus.stage), 32'd3);
    wait_cyc(s + 10);
    bus.mem_ready = 1'b1;
    wait_cyc(s + 13);
    chk("t3_halt", 32'(bus.mode), 32'd3);
    chk("t3_retired", bus.retired, 32'd1);
    bus.stop_req = 1'b0;
    drain("queue_t3");

    // single step, then stop together with step_en
    do_reset();
    bus.step_en = 1'b1;
    boot(s);
    push_instr(s, 0, 0, 0, 0, 0, 0, n);
    wait_cyc(s + 10);
    chk("pause_stage", 32'(bus.stage), 32'd6);
    chk("pause_retired", bus.retired, 32'd1);
    wait_cyc(s + 15);
    bus.step_go = 1'b1;
    tick();
    bus.step_go = 1'b0;
    push_instr(s + 16, 0, 0, 0, 0, 0, 0, n);
    wait_cyc(s + 25);
    chk("pause2_stage", 32'(bus.stage), 32'd6);
    bus.step_go = 1'b1;
    bus.stop_req = 1'b1;
    tick();
    bus.step_go = 1'b0;
    push_instr(s + 26, 0, 0, 0, 0, 0, 0, n);
    wait_cyc(s + 32);
    chk("t4_halt", 32'(bus.mode), 32'd3);
    chk("t4_stage", 32'(bus.stage), 32'd5);
    chk("t4_retired", bus.retired, 32'd3);
    bus.stop_req = 1'b0;
    bus.step_en = 1'b0;
    drain("queue_t4");

    // reset during the second instruction's EXECUTE
    bus.lat_cfg = 20'h00300;
    do_reset();
    boot(s);
    push_instr(s, 0, 0, 3, 0, 0, 0, n);
    push_ev(0, s + 10);
    push_ev(1, s + 11);
    wait_cyc(s + 12);
    chk("pre_rst_stage", 32'(bus.stage), 32'd2);
    chk("pre_rst_pc", 32'(bus.pc), 32'd5);
    chk("pre_rst_retired", bus.retired, 32'd1);
    rstn = 1'b0;
    tick();
    chk("mid_rst_mode", 32'(bus.mode), 32'd0);
    chk("mid_rst_stage", 32'(bus.stage), 32'd0);
    chk("mid_rst_pc", 32'(bus.pc), 32'd0);
    chk("mid_rst_retired", bus.retired, 32'd0);
    chk("mid_rst_pulses", 32'({bus.wb_clr, bus.wb_en, bus.mw_en, bus.em_en, bus.de_en, bus.fd_en}), 32'd0);
    rstn = 1'b1;
    drain("queue_t5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
